// File: rtl/p2s_s2p_lanes_param.sv
// p2s_s2p_lanes_param: single-clock multi-lane serialiser/deserialiser.
// TX serialises one LANES*WIDTH word per WIDTH cycles (COMMA fills idle
// symbol times). RX hunts/locks on COMMA per lane, deskews lanes to a
// common symbol time and reassembles the word.
// Optional macro P2S_S2P_LOOPBACK_EN adds IN_LOOPBACK (RX takes OUT_SERIAL).
module p2s_s2p_lanes_param #(
  parameter int               LANES      = 4,
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int               LOCK_COUNT = 2
) (
  input  logic                   IN_CLK,
  input  logic                   IN_RESET,
  input  logic                   IN_ENB,
  input  logic [LANES*WIDTH-1:0] IN_DATA,
  input  logic                   IN_VALID,
  output logic                   OUT_READY,
  output logic [LANES-1:0]       OUT_SERIAL,
  input  logic [LANES-1:0]       IN_SERIAL,
`ifdef P2S_S2P_LOOPBACK_EN
  input  logic                   IN_LOOPBACK,
`endif
  output logic [LANES*WIDTH-1:0] OUT_DATA,
  output logic                   OUT_VALID,
  output logic [LANES-1:0]       OUT_LANE_LOCKED,
  output logic                   OUT_LOCKED,
  output logic                   OUT_SKEW_ERR
);

  localparam int CW = $clog2(WIDTH);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  // TX state
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [WIDTH-1:0] tx_shift_q [LANES];
  logic [WIDTH-1:0] tx_shift_d [LANES];
  logic             tx_accept;

  // RX per-lane state
  rx_state_e        state_q    [LANES];
  rx_state_e        state_d    [LANES];
  logic [CW-1:0]    rx_cnt_q   [LANES];
  logic [CW-1:0]    rx_cnt_d   [LANES];
  logic [LW-1:0]    lk_cnt_q   [LANES];
  logic [LW-1:0]    lk_cnt_d   [LANES];
  logic [WIDTH-2:0] rx_shift_q [LANES];
  logic [WIDTH-2:0] rx_shift_d [LANES];
  logic [WIDTH-1:0] sym_q      [LANES];
  logic [WIDTH-1:0] sym_d      [LANES];
  logic [WIDTH-1:0] rx_win     [LANES];
  logic [LANES-1:0] rx_bnd, rx_comma, rx_load, lane_locked, rx_in;

  // Deskew / output state
  logic [LANES-1:0]       fresh_q, fresh_d;
  logic                   skew_err_q, skew_err_d;
  logic [LANES*WIDTH-1:0] out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic [LANES*WIDTH-1:0] sym_cat;
  logic                   all_comma, all_locked, deskew_clr;

`ifdef P2S_S2P_LOOPBACK_EN
  assign rx_in = IN_LOOPBACK ? OUT_SERIAL : IN_SERIAL;
`else
  assign rx_in = IN_SERIAL;
`endif

  assign OUT_READY  = IN_ENB && (tx_cnt_q == CNT_LAST);
  assign tx_accept  = IN_VALID && OUT_READY;
  assign all_locked = &lane_locked;
  assign OUT_LANE_LOCKED = lane_locked;
  assign OUT_LOCKED      = all_locked;
  assign OUT_DATA        = out_data_q;
  assign OUT_VALID       = out_valid_q && IN_ENB;
  assign OUT_SKEW_ERR    = skew_err_q;

  // TX: shared symbol counter; load word or COMMA at the last bit, else shift out MSB-first
  always_comb begin
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    if (IN_ENB) begin
      if (tx_cnt_q == CNT_LAST) begin
        tx_cnt_d = '0;
        for (int k = 0; k < LANES; k++)
          tx_shift_d[k] = tx_accept ? IN_DATA[k*WIDTH +: WIDTH] : COMMA;
      end else begin
        tx_cnt_d = tx_cnt_q + CW'(1);
        for (int k = 0; k < LANES; k++)
          tx_shift_d[k] = {tx_shift_q[k][WIDTH-2:0], 1'b0};
      end
    end
  end

  // Per-lane window, boundary and lock decode shared by the RX and deskew logic
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      OUT_SERIAL[k]  = tx_shift_q[k][WIDTH-1];
      rx_win[k]      = {rx_shift_q[k], rx_in[k]};
      rx_bnd[k]      = (rx_cnt_q[k] == CNT_LAST);
      rx_comma[k]    = (rx_win[k] == COMMA);
      lane_locked[k] = (state_q[k] == LOCKED);
    end
  end

  // RX lanes: HUNT finds a comma, CHECK confirms LOCK_COUNT aligned commas, LOCKED captures symbols
  always_comb begin
    state_d    = state_q;
    rx_cnt_d   = rx_cnt_q;
    lk_cnt_d   = lk_cnt_q;
    rx_shift_d = rx_shift_q;
    sym_d      = sym_q;
    rx_load    = '0;
    if (IN_ENB) begin
      for (int k = 0; k < LANES; k++) begin
        rx_shift_d[k] = rx_win[k][WIDTH-2:0];
        rx_cnt_d[k]   = rx_bnd[k] ? '0 : rx_cnt_q[k] + CW'(1);
        case (state_q[k])
          HUNT: begin
            if (rx_comma[k]) begin
              rx_cnt_d[k] = '0;
              lk_cnt_d[k] = LW'(1);
              state_d[k]  = (LOCK_COUNT == 1) ? LOCKED : CHECK;
            end
          end
          CHECK: begin
            if (rx_bnd[k]) begin
              if (rx_comma[k]) begin
                lk_cnt_d[k] = lk_cnt_q[k] + LW'(1);
                if (int'(lk_cnt_q[k]) + 1 >= LOCK_COUNT) state_d[k] = LOCKED;
              end else begin
                state_d[k] = HUNT;
              end
            end
          end
          LOCKED: begin
            if (rx_bnd[k]) begin
              sym_d[k]   = rx_win[k];
              rx_load[k] = 1'b1;
            end else if (rx_comma[k]) begin
              // A comma off the boundary means the lane slipped: realign here and re-verify
              rx_cnt_d[k] = '0;
              lk_cnt_d[k] = LW'(1);
              state_d[k]  = CHECK;
            end
          end
          default: state_d[k] = HUNT;
        endcase
      end
    end
  end

  // Deskew: once every lane holds a fresh symbol, emit the word (unless all-idle) and clear fresh
  always_comb begin
    sym_cat   = '0;
    all_comma = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      sym_cat[k*WIDTH +: WIDTH] = sym_q[k];
      if (sym_q[k] != COMMA) all_comma = 1'b0;
    end
    deskew_clr = IN_ENB && all_locked && (&fresh_q);
    fresh_d    = fresh_q;
    for (int k = 0; k < LANES; k++) begin
      if (rx_load[k])      fresh_d[k] = 1'b1;
      else if (deskew_clr) fresh_d[k] = 1'b0;
    end
    // A reload while still unconsumed is an overrun; a reload on the consuming edge is fine
    skew_err_d  = skew_err_q | (|(rx_load & fresh_q & ~{LANES{deskew_clr}}));
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (IN_ENB) begin
      out_valid_d = deskew_clr && !all_comma;
      if (deskew_clr && !all_comma) out_data_d = sym_cat;
    end
  end

  // State registers; asynchronous reset returns the link to idle/HUNT
  always_ff @(posedge IN_CLK or posedge IN_RESET) begin
    if (IN_RESET) begin
      tx_cnt_q <= CNT_LAST;
      for (int k = 0; k < LANES; k++) begin
        tx_shift_q[k] <= '0;
        state_q[k]    <= HUNT;
        rx_cnt_q[k]   <= '0;
        lk_cnt_q[k]   <= '0;
        rx_shift_q[k] <= '0;
        sym_q[k]      <= '0;
      end
      fresh_q     <= '0;
      skew_err_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      tx_cnt_q    <= tx_cnt_d;
      tx_shift_q  <= tx_shift_d;
      state_q     <= state_d;
      rx_cnt_q    <= rx_cnt_d;
      lk_cnt_q    <= lk_cnt_d;
      rx_shift_q  <= rx_shift_d;
      sym_q       <= sym_d;
      fresh_q     <= fresh_d;
      skew_err_q  <= skew_err_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_p2s_s2p_lanes_param.sv
// Testbench for p2s_s2p_lanes_param in loopback (lane 2 through an optional
// delay line). Expected words come from a queue of accepted non-idle words,
// each tagged with the enabled-cycle count at which it must emerge.
module tb_p2s_s2p_lanes_param;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam logic [31:0] IDLE_W = {4{COMMA}};

  logic        clk, in_rst, in_enb, in_valid, out_ready, out_valid, out_locked, out_skew_err;
  logic [31:0] in_data, out_data;
  logic [3:0]  out_serial, in_serial, out_lane_locked;
  logic [15:0] dly;
  int          dly_n;

  p2s_s2p_lanes_param #(.LANES(4), .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(2)) dut (
    .IN_CLK(clk), .IN_RESET(in_rst), .IN_ENB(in_enb), .IN_DATA(in_data),
    .IN_VALID(in_valid), .OUT_READY(out_ready), .OUT_SERIAL(out_serial),
    .IN_SERIAL(in_serial), .OUT_DATA(out_data), .OUT_VALID(out_valid),
    .OUT_LANE_LOCKED(out_lane_locked), .OUT_LOCKED(out_locked), .OUT_SKEW_ERR(out_skew_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) dly <= {dly[14:0], out_serial[2]};

  always_comb begin
    in_serial = out_serial;
    if (dly_n != 0) in_serial[2] = dly[dly_n-1];
  end

  typedef struct {logic [31:0] data; int due;} exp_t;
  exp_t q[$];
  int   pop_cyc[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, en_cyc = 0, lat_extra = 0, acc_cyc = 0;
  bit   acc_last;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // No window that straddles a symbol pair (at a non-zero offset) may look like COMMA
  function automatic bit ok_pair(logic [7:0] a, logic [7:0] b);
    logic [15:0] s;
    s = {a, b};
    for (int j = 1; j < 8; j++) if (s[15-j -: 8] == COMMA) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] gen_word(logic [31:0] p);
    logic [31:0] w;
    logic [7:0]  s, ps;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      ps = p[k*8 +: 8];
      if ($urandom_range(0, 7) == 0) s = COMMA;
      else begin
        s = 8'($urandom);
        for (int t = 0; t < 200 && !(ok_pair(ps, s) && ok_pair(s, COMMA) && ok_pair(COMMA, s)); t++)
          s = 8'($urandom);
        if (!(ok_pair(ps, s) && ok_pair(s, COMMA) && ok_pair(COMMA, s))) s = COMMA;
      end
      w[k*8 +: 8] = s;
    end
    return w;
  endfunction

  task automatic step();
    exp_t e;
    acc_last = 1'b0;
    if (in_enb && in_valid && out_ready && !in_rst) begin
      acc_last = 1'b1;
      acc_cyc  = cyc + 1;
      if (in_data != IDLE_W) q.push_back('{in_data, en_cyc + 1 + 9 + lat_extra});
    end
    @(posedge clk);
    cyc++;
    if (in_enb && !in_rst) en_cyc++;
    #1;
    if (out_valid) begin
      if (q.size() == 0) check("valid_without_word", 64'(out_valid), 64'(0));
      else begin
        e = q.pop_front();
        check("rx_data", 64'(out_data), 64'(e.data));
        check("rx_latency", 64'(en_cyc), 64'(e.due));
        pop_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic send_word(logic [31:0] w);
    in_data  = w;
    in_valid = 1'b1;
    for (int g = 0; g < 20; g++) begin
      step();
      if (acc_last) break;
    end
    check("accept", 64'(acc_last), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(int max);
    for (int g = 0; g < max; g++) begin
      if (q.size() == 0) break;
      step();
    end
    check("drain", 64'(q.size()), 64'(0));
  endtask

  task automatic check_rst(string tag);
    check({tag, "_serial"}, 64'(out_serial), 64'(0));
    check({tag, "_data"}, 64'(out_data), 64'(0));
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_lane_locked"}, 64'(out_lane_locked), 64'(0));
    check({tag, "_locked"}, 64'(out_locked), 64'(0));
    check({tag, "_skew"}, 64'(out_skew_err), 64'(0));
    check({tag, "_ready"}, 64'(out_ready), 64'(in_enb));
  endtask

  task automatic relock_exact(string tag);
    for (int i = 1; i <= 16; i++) step();
    check({tag, "_locked_e16"}, 64'(out_locked), 64'(0));
    step();
    check({tag, "_locked_e17"}, 64'(out_locked), 64'(1));
  endtask

  task automatic do_reset(int d);
    in_rst = 1'b1;
    dly_n  = d;
    #1;
    check_rst("rst");
    q.delete();
    repeat (12) step();
    in_rst = 1'b0;
  endtask

  task automatic wait_lock(int max);
    for (int g = 0; g < max; g++) begin
      if (out_locked) break;
      step();
    end
    check("wait_lock", 64'(out_locked), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ser [4];
    logic [31:0] w, prev;
    logic [3:0]  os_frz;
    int          a0, guard;
    in_rst = 1'b1; in_enb = 1'b1; in_valid = 1'b0; in_data = '0; dly_n = 0;
    for (int k = 0; k < 4; k++) ser[k] = '0;

    // Reset, idle commas MSB-first, lock on the 17th edge
    #1;
    check_rst("reset");
    repeat (12) step();
    in_rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      for (int k = 0; k < 4; k++) ser[k] = {ser[k][6:0], out_serial[k]};
    end
    for (int k = 0; k < 4; k++) check($sformatf("idle_comma_lane%0d", k), 64'(ser[k]), 64'(COMMA));
    for (int i = 9; i <= 16; i++) step();
    check("lock_e16", 64'(out_locked), 64'(0));
    step();
    check("lock_e17", 64'(out_locked), 64'(1));
    check("lane_locked", 64'(out_lane_locked), 64'(4'hF));
    repeat (10) step();

    // Single word, 9-cycle latency, one-cycle valid
    pop_cyc.delete();
    send_word(32'hDEADBEEF);
    a0 = acc_cyc;
    wait_drain(30);
    check("deadbeef_lat", 64'(pop_cyc[0] - a0), 64'(9));
    step();
    check("valid_one_cycle", 64'(out_valid), 64'(0));

    // All-COMMA word is idle: no valid, OUT_DATA holds
    send_word(IDLE_W);
    repeat (20) step();
    check("idle_hold_data", 64'(out_data), 64'(32'hDEADBEEF));

    // Back-to-back words
    pop_cyc.delete();
    send_word(32'h00000001); a0 = acc_cyc;
    send_word(32'h00000002); check("ready_period2", 64'(acc_cyc - a0), 64'(8)); a0 = acc_cyc;
    send_word(32'h00000003); check("ready_period3", 64'(acc_cyc - a0), 64'(8)); a0 = acc_cyc;
    send_word(32'h00000004); check("ready_period4", 64'(acc_cyc - a0), 64'(8));
    wait_drain(40);
    check("b2b_count", 64'(pop_cyc.size()), 64'(4));
    for (int i = 1; i < pop_cyc.size(); i++)
      check("b2b_valid_spacing", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'(8));
    check("b2b_skew", 64'(out_skew_err), 64'(0));
    repeat (10) step();

    // Randomised traffic with random gaps
    prev = IDLE_W;
    w = gen_word(prev);
    guard = 0;
    for (int n = 0; n < 30 && guard < 3000; guard++) begin
      in_data  = w;
      in_valid = ($urandom_range(0, 2) != 0);
      step();
      if (acc_last) begin
        prev = w;
        w = gen_word(prev);
        n++;
      end
    end
    in_valid = 1'b0;
    wait_drain(40);
    check("rand_skew", 64'(out_skew_err), 64'(0));
    repeat (10) step();

    // Enable low for 5 cycles mid-symbol
    pop_cyc.delete();
    send_word(32'h12345678);
    a0 = acc_cyc;
    repeat (3) step();
    os_frz = out_serial;
    in_enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("frz_ready", 64'(out_ready), 64'(0));
      check("frz_valid", 64'(out_valid), 64'(0));
      check("frz_serial", 64'(out_serial), 64'(os_frz));
      check("frz_lane_locked", 64'(out_lane_locked), 64'(4'hF));
    end
    in_enb = 1'b1;
    wait_drain(30);
    check("enb_lat", 64'(pop_cyc[0] - a0), 64'(14));
    repeat (10) step();

    // Reset mid-symbol with a word in flight
    send_word(32'hCAFEF00D);
    repeat (3) step();
    #4 in_rst = 1'b1;
    #1;
    check_rst("midrst");
    q.delete();
    repeat (4) step();
    in_rst = 1'b0;
    relock_exact("midrst");
    repeat (5) step();
    send_word(32'h5A5A5A5A);
    wait_drain(30);
    repeat (5) step();

    // Lane 2 delayed 3 cycles: tolerated
    do_reset(3);
    lat_extra = 3;
    wait_lock(60);
    repeat (10) step();
    send_word(32'hA5A55A5A);
    wait_drain(40);
    repeat (20) step();
    check("skew3_err", 64'(out_skew_err), 64'(0));
    lat_extra = 0;

    // Lane 2 delayed 9 cycles: overrun, sticky
    do_reset(9);
    wait_lock(60);
    repeat (20) step();
    check("skew9_err", 64'(out_skew_err), 64'(1));
    repeat (40) step();
    check("skew9_sticky", 64'(out_skew_err), 64'(1));

    // Reset clears the sticky error
    #4 in_rst = 1'b1;
    #1;
    check_rst("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/p2s_s2p_lanes_param.md
Name: p2s_s2p_lanes_param

Overview:
- Parametrised single-clock PCIe-style lane SerDes: the successor to the fixed 4x8-bit, two-clock parallel/serial link.
- TX side: accepts a LANES*WIDTH-bit word through a valid/ready handshake and serialises each lane MSB-first. Idle symbol times are filled with a COMMA symbol.
- RX side: per-lane comma hunt/check/lock alignment, cross-lane deskew within one symbol time, and word reassembly.
- Sits between the link-layer parallel datapath and the physical lane wires.

Parameters:
- LANES, 4: number of serial lanes.
- WIDTH, 8: bits per lane symbol, at least 4.
- COMMA, 8'hBC (WIDTH bits): idle/alignment symbol.
- LOCK_COUNT, 2: consecutive aligned commas required to lock, at least 1.

Ports:
- IN_CLK  in  1  bit clock; one serial bit per lane per cycle.
- IN_RESET  in  1  reset; asynchronous, active-high.
- IN_ENB  in  1  global enable; low freezes all state.
- IN_DATA  in  LANES*WIDTH  TX word; lane k = [k*WIDTH +: WIDTH].
- IN_VALID  in  1  TX word valid.
- OUT_READY  out  1  TX can accept a word this cycle.
- OUT_SERIAL  out  LANES  TX serial bit per lane.
- IN_SERIAL  in  LANES  RX serial bit per lane.
- OUT_DATA  out  LANES*WIDTH  reassembled RX word.
- OUT_VALID  out  1  OUT_DATA valid, one-cycle pulse.
- OUT_LANE_LOCKED  out  LANES  per-lane lock status.
- OUT_LOCKED  out  1  AND of OUT_LANE_LOCKED.
- OUT_SKEW_ERR  out  1  sticky; a lane overran deskew.

Behaviour:
- Interface: one clock, IN_CLK. Reset IN_RESET is asynchronous and active-high.
- IN_ENB low: every register holds its value, OUT_READY=0, OUT_VALID=0.

Reset values:
- tx_cnt=WIDTH-1; TX shift registers=0, so OUT_SERIAL=0.
- All RX lanes in HUNT; OUT_LANE_LOCKED=0, OUT_LOCKED=0.
- OUT_DATA=0, OUT_VALID=0, OUT_SKEW_ERR=0.
- OUT_READY is combinational: IN_ENB && tx_cnt==WIDTH-1, so during reset it equals IN_ENB.

TX:
- One shared counter tx_cnt wraps WIDTH-1 -> 0.
- Accept = IN_VALID && OUT_READY.
- At the edge where tx_cnt==WIDTH-1, every lane shift register loads its IN_DATA slice if accepted, otherwise COMMA.
- On all other edges the shift registers shift left. OUT_SERIAL[k] = shift_k MSB.
- Each symbol occupies exactly WIDTH cycles. Sustained throughput is one word per WIDTH cycles.
- IN_DATA is sampled only at the accept edge.

RX, per lane:
- shift_k holds the last WIDTH-1 bits.
- window = {shift_k[WIDTH-2:0], IN_SERIAL[k]}; every comparison uses window.
- Boundary edge = an edge where rx_cnt_k == WIDTH-1.

RX lane states:
- HUNT: window==COMMA sets rx_cnt_k so that this edge is a boundary and sets cnt=1. Go to CHECK, or straight to LOCKED if LOCK_COUNT==1.
- CHECK, at a boundary: window==COMMA increments cnt. When cnt reaches LOCK_COUNT, go to LOCKED. window!=COMMA returns to HUNT.
- LOCKED, at a boundary: window loads sym_k and sets fresh_k. A COMMA window at a non-boundary edge realigns to that edge and goes to CHECK with cnt=1.
- OUT_LANE_LOCKED[k] = (state==LOCKED), registered.

Deskew / output:
- When all fresh_k are set and OUT_LOCKED=1, the next edge clears all fresh_k.
- At that same edge, if not every sym_k==COMMA: OUT_DATA <= concatenated sym, OUT_VALID <= 1 for one cycle.
- An all-COMMA word is idle: OUT_DATA holds and OUT_VALID stays 0.
- Latency, zero skew in loopback: OUT_VALID high WIDTH+1 cycles after the accept edge.
- A lane setting fresh while already fresh overwrites sym_k and sets OUT_SKEW_ERR. OUT_SKEW_ERR clears only on reset.
- Tolerated lane skew is at most WIDTH-1 cycles.
- A payload lane equal to COMMA at a boundary is delivered as data. It is treated as idle only if all lanes are COMMA.

Reset mid-operation:
- All state returns to reset values immediately, regardless of IN_CLK.
- In-flight words are dropped; the lanes relock from HUNT.

Optional Feature:
- Macro: P2S_S2P_LOOPBACK_EN.
- Defined: adds input port IN_LOOPBACK (1 bit), placed after IN_SERIAL. When IN_LOOPBACK=1, RX lane k uses OUT_SERIAL[k] in place of IN_SERIAL[k]. Switching IN_LOOPBACK mid-stream is allowed; RX relocks per the normal rules.
- Undefined: no IN_LOOPBACK port; RX always uses IN_SERIAL.

Test Plan (LANES=4, WIDTH=8, COMMA=8'hBC, LOCK_COUNT=2, IN_SERIAL wired to OUT_SERIAL, IN_ENB=1):
- Reset, then IN_VALID=0 -> OUT_SERIAL carries 8'hBC per lane MSB-first; OUT_LOCKED=1 after the 17th edge after release; OUT_VALID never asserted.
- After lock, IN_DATA=32'hDEADBEEF accepted -> OUT_DATA=32'hDEADBEEF with a 1-cycle OUT_VALID, 9 cycles after the accept edge.
- IN_VALID held high with 4 words (32'h00000001..32'h00000004) -> OUT_READY pulses every 8 cycles; 4 OUT_VALID pulses 8 cycles apart, data in order; OUT_SKEW_ERR=0.
- Lane 2 delayed 3 cycles -> 32'hA5A55A5A reassembled correctly, OUT_SKEW_ERR=0. Lane 2 delayed 9 cycles -> OUT_SKEW_ERR=1 and stays set.
- IN_RESET pulsed mid-symbol -> all outputs at reset values within the same cycle; the link relocks 17 edges after release.
- IN_ENB low for 5 cycles mid-symbol of 32'h12345678 -> OUT_SERIAL, OUT_READY=0 and RX state frozen; word still delivered intact 5 cycles later than nominal.
